au_dec_c_pipe: RTL and testbench
================================

// Module: au_dec_c_pipe
// PURPOSE
//  Pipelined, flow-controlled decrementer with carry-in (borrow-in) and carry-out (borrow-out).
//  The WIDTH-bit borrow chain is split into STAGES segments, one register stage per segment.
//  Each beat computes z = (a - ci) mod 2^WIDTH and co = borrow-out.
//  Serves wide datapaths (counters, address generators) where a single-cycle AU_dec_c misses timing.
// PARAMETERS
//  WIDTH   8  operand word length, >= 1
//  ARCH    0  per-segment architecture: 0 ripple, 1 parallel-prefix; result is bit-identical
//  STAGES  2  pipeline depth = number of segments, 1 <= STAGES <= WIDTH
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block accepts input this cycle
//  a          in   WIDTH  operand
//  ci         in   1      carry-in (borrow): 1 subtracts one, 0 passes a through
//  out_valid  out  1      output beat valid
//  out_ready  in   1      downstream accepts output this cycle
//  z          out  WIDTH  result (a - ci) mod 2^WIDTH
//  co         out  1      borrow-out: 1 iff ci==1 and a==0
// BEHAVIOUR
//  - Segment width SW = ceil(WIDTH/STAGES). Segment k covers bits [k*SW, min((k+1)*SW, WIDTH)-1].
//    The last segment may be narrower. An empty segment is illegal: STAGES must satisfy (STAGES-1)*SW < WIDTH.
//  - Stage k registers:
//    - valid_k.
//    - The result bits of segments 0..k.
//    - The still-unprocessed a bits of segments k+1..STAGES-1 (skew registers).
//    - The borrow into segment k+1.
//  - Stage 0 consumes ci. The borrow out of segment k feeds segment k+1 one cycle later.
//  - co = borrow out of the top segment, registered in the last stage.
//  - Flow control is a global stall:
//    - adv = ~out_valid | out_ready; in_ready = adv (combinational, no in_valid dependency).
//    - If adv: every stage loads from its predecessor; stage 0 loads (in_valid, a, ci).
//    - If ~adv: all stage registers hold.
//  - Transfer rules:
//    - A beat is accepted iff in_valid & in_ready.
//    - A beat is delivered iff out_valid & out_ready.
//  - Latency: exactly STAGES cycles from acceptance to out_valid, with no stall in between.
//    Throughput: 1 beat/cycle while out_ready=1.
//  - Bubbles (in_valid=0 while adv) propagate as valid=0. Bubbles are squeezed only by stalls, never reordered.
//  - Ordering: strictly FIFO; no beat is dropped or duplicated.
//  - Output stability: while out_valid=1 and out_ready=0, z/co/out_valid hold their values exactly.
//  - Reset, including mid-stream:
//    - All valid_k, out_valid and co become 0; z becomes 0; in-flight beats are discarded.
//    - in_ready = 1 in the cycle after reset deasserts.
//    - While rst=1, in_ready = 0 and no beat is accepted.
//  - Boundary values:
//    - a=0, ci=1 -> z=all-ones, co=1 (wrap-around).
//    - a=0, ci=0 -> z=0, co=0.
//    - a=all-ones, ci=1 -> z=all-ones-1, co=0.
//  - Simultaneous events: out_ready=1 with a full pipe and in_valid=1 accepts and delivers in the same cycle.
//  - STAGES=1: one register stage, latency 1; z/co equal AU_dec_c registered.
//  - No X propagation from a/ci when in_valid=0: the payload registers still load, but out_valid masks them.
// TESTING (WIDTH=8, STAGES=2 unless stated)
//  1. Reset, then a=8'h00 ci=1 in_valid=1 out_ready=1 -> 2 cycles later out_valid=1, z=8'hFF, co=1.
//  2. Back-to-back (8'h10,1), (8'h10,0), (8'h80,1), (8'hFF,1), out_ready=1
//     -> consecutive outputs (0F,0), (10,0), (7F,0), (FE,0), one per cycle.
//  3. Full pipe with out_ready=0 for 5 cycles
//     -> in_ready=0, z/co frozen; releasing delivers all beats in order, none lost.
//  4. Assert rst for 1 cycle with 2 beats in flight
//     -> out_valid=0, z=0, co=0 next cycle; discarded beats never appear.
//  5. WIDTH=12, STAGES=5 (SW=3, last segment 0 bits, illegal) is rejected.
//     WIDTH=12, STAGES=4: 1000 random beats with random out_ready stalls
//     -> every output matches the reference model (a-ci, borrow).
//  6. WIDTH=8, STAGES=1 and STAGES=8, ARCH=0/1: exhaustive a x ci
//     -> all 512 results match, latency equals STAGES.

Source files
------------

// File: rtl/au_dec_c_pipe.sv
// au_dec_c_pipe: pipelined, flow-controlled decrementer with borrow-in/borrow-out.
// The WIDTH-bit borrow chain is cut into STAGES segments of SW = ceil(WIDTH/STAGES)
// bits. Stage k resolves segment k, so the register of stage k holds the finished
// result bits of segments 0..k in its low part and the not-yet-processed operand
// bits of segments k+1.. in its high part (the skew). The borrow out of segment k
// is registered alongside and feeds segment k+1 one cycle later.
//
// Handshake: a beat moves on the input when in_valid & in_ready, and on the output
// when out_valid & out_ready. The whole pipe advances together (adv) whenever the
// output register is empty or being drained; otherwise every stage holds, which
// keeps z/co/out_valid frozen while the consumer stalls. in_ready never depends
// on in_valid, and is forced low while rst is asserted.
module au_dec_c_pipe #(
    parameter int WIDTH  = 8,
    parameter int ARCH   = 0,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             co
);

    localparam int SW = (WIDTH + STAGES - 1) / STAGES;

    // Parameter sets that would leave a segment with no bits are refused at
    // elaboration rather than silently producing a zero-width stage.
    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (STAGES - 1) * SW >= WIDTH) begin : g_bad_params
        $error("au_dec_c_pipe: illegal WIDTH/STAGES combination (empty segment)");
    end

    logic adv;

    // Global advance: the pipe moves when the output slot is free or being taken.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam int HI = ((k + 1) * SW < WIDTH) ? (k + 1) * SW - 1 : WIDTH - 1;
        localparam int N  = HI - LO + 1;

        logic             src_v;
        logic             src_b;
        logic [WIDTH-1:0] src_d;
        logic [N-1:0]     seg_in;
        logic [N-1:0]     seg_out;
        logic [N:0]       bin;      // bin[i] = borrow into segment bit i, bin[N] = borrow out
        logic [WIDTH-1:0] nxt_d;

        logic             valid_q;
        logic             borrow_q;
        logic [WIDTH-1:0] data_q;

        // Stage 0 takes the raw beat; later stages take the previous stage register.
        if (k == 0) begin : g_src
            assign src_v = in_valid;
            assign src_d = a;
            assign src_b = ci;
        end else begin : g_src
            assign src_v = g_stage[k-1].valid_q;
            assign src_d = g_stage[k-1].data_q;
            assign src_b = g_stage[k-1].borrow_q;
        end

        assign seg_in = src_d[HI:LO];

        if (ARCH == 0) begin : g_ripple
            // Ripple borrow: a borrow passes a bit only where that bit is zero.
            always_comb begin
                bin[0] = src_b;
                for (int i = 0; i < N; i++) begin
                    bin[i+1] = bin[i] & ~seg_in[i];
                end
            end
        end else begin : g_prefix
            // Log-depth prefix AND of "bit is zero"; the low d positions are padded
            // with ones at each level so they pass their value through unchanged.
            always_comb begin
                logic [N-1:0] zp;
                zp = ~seg_in;
                for (int d = 1; d < N; d = d * 2) begin
                    zp = zp & ((zp << d) | ~({N{1'b1}} << d));
                end
                bin[0]   = src_b;
                bin[N:1] = {N{src_b}} & zp;
            end
        end

        // A bit flips exactly when a borrow arrives at it.
        assign seg_out = seg_in ^ bin[N-1:0];

        // Splice the processed segment into the word; other bits pass unchanged.
        always_comb begin
            nxt_d        = src_d;
            nxt_d[HI:LO] = seg_out;
        end

        // Stage register: cleared by reset, loaded on advance, held on stall.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q  <= 1'b0;
                borrow_q <= 1'b0;
                data_q   <= '0;
            end else if (adv) begin
                valid_q  <= src_v;
                borrow_q <= bin[N];
                data_q   <= nxt_d;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign z         = g_stage[STAGES-1].data_q;
    assign co        = g_stage[STAGES-1].borrow_q;

endmodule

// File: tb/tb_au_dec_c_pipe.sv
// Testbench for au_dec_c_pipe. Four instances share one clock and reset:
//   dut    WIDTH=8  STAGES=2 ARCH=0  (directed tests, stalls, exhaustive)
//   dut2   WIDTH=12 STAGES=4 ARCH=1  (random beats with random stalls)
//   dut_s1 WIDTH=8  STAGES=1 ARCH=1  (fed like dut, never stalled)
//   dut_s8 WIDTH=8  STAGES=8 ARCH=0  (fed like dut, never stalled)
// Each instance has a scoreboard computing expected results with integer
// arithmetic when a beat is accepted and comparing when one is delivered.
module tb_au_dec_c_pipe;

    localparam int S  = 2;
    localparam int S2 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tie_one = 1'b1;

    logic        in_valid = 1'b0, in_ready, ci = 1'b0, out_valid, out_ready = 1'b1, co;
    logic [7:0]  a = '0, z;
    logic        in_valid2 = 1'b0, in_ready2, ci2 = 1'b0, out_valid2, out_ready2 = 1'b1, co2;
    logic [11:0] a2 = '0, z2;
    logic        in_ready_s1, out_valid_s1, co_s1;
    logic [7:0]  z_s1;
    logic        in_ready_s8, out_valid_s8, co_s8;
    logic [7:0]  z_s8;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit lat_chk  = 1'b0;

    logic [8:0]  exp_q[$];
    int          t_q[$];
    logic [11+1:0] exp2_q[$];
    logic [8:0]  exp_s1_q[$];
    int          t_s1_q[$];
    logic [8:0]  exp_s8_q[$];
    int          t_s8_q[$];

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    au_dec_c_pipe #(.WIDTH(8), .ARCH(0), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .ci(ci),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .co(co));

    au_dec_c_pipe #(.WIDTH(12), .ARCH(1), .STAGES(S2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .ci(ci2),
        .out_valid(out_valid2), .out_ready(out_ready2), .z(z2), .co(co2));

    au_dec_c_pipe #(.WIDTH(8), .ARCH(1), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s1), .a(a), .ci(ci),
        .out_valid(out_valid_s1), .out_ready(tie_one), .z(z_s1), .co(co_s1));

    au_dec_c_pipe #(.WIDTH(8), .ARCH(0), .STAGES(8)) dut_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s8), .a(a), .ci(ci),
        .out_valid(out_valid_s8), .out_ready(tie_one), .z(z_s8), .co(co_s8));

    // Reference: r = a - ci as a plain integer; a negative r means a borrow out
    // and wraps by 2^w. Returned packed as {co, z}.
    function automatic int model(input int w, input int av, input int c);
        int r;
        r = av - c;
        if (r < 0) return (1 << w) + (r + (1 << w));
        return r;
    endfunction

    // Scoreboard for dut (latency checked only while lat_chk is set).
    always @(negedge clk) begin
        logic [8:0] e;
        int t0;
        if (rst) begin
            exp_q.delete(); t_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_main extra beat got co=%b z=%h", co, z);
                end else begin
                    e = exp_q.pop_front(); t0 = t_q.pop_front();
                    if ({co, z} !== e) begin
                        failures++;
                        $display("FAIL sb_main got co=%b z=%h expected co=%b z=%h", co, z, e[8], e[7:0]);
                    end else if (lat_chk && (cyc - t0) != S) begin
                        failures++;
                        $display("FAIL lat_main got %0d expected %0d", cyc - t0, S);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(9'(model(8, int'(a), int'(ci))));
                t_q.push_back(cyc);
            end
        end
    end

    // Scoreboard for dut2.
    always @(negedge clk) begin
        logic [12:0] e;
        if (rst) begin
            exp2_q.delete();
        end else begin
            if (out_valid2 && out_ready2) begin
                checks++;
                if (exp2_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_w12 extra beat got co=%b z=%h", co2, z2);
                end else begin
                    e = exp2_q.pop_front();
                    if ({co2, z2} !== e) begin
                        failures++;
                        $display("FAIL sb_w12 got co=%b z=%h expected co=%b z=%h", co2, z2, e[12], e[11:0]);
                    end
                end
            end
            if (in_valid2 && in_ready2) exp2_q.push_back(13'(model(12, int'(a2), int'(ci2))));
        end
    end

    // Scoreboard for dut_s1 (never stalled, so latency is always checked).
    always @(negedge clk) begin
        logic [8:0] e;
        int t0;
        if (rst) begin
            exp_s1_q.delete(); t_s1_q.delete();
        end else begin
            if (out_valid_s1) begin
                checks++;
                if (exp_s1_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_s1 extra beat got co=%b z=%h", co_s1, z_s1);
                end else begin
                    e = exp_s1_q.pop_front(); t0 = t_s1_q.pop_front();
                    if ({co_s1, z_s1} !== e || (cyc - t0) != 1) begin
                        failures++;
                        $display("FAIL sb_s1 got co=%b z=%h lat=%0d expected co=%b z=%h lat=1",
                                 co_s1, z_s1, cyc - t0, e[8], e[7:0]);
                    end
                end
            end
            if (in_valid && in_ready_s1) begin
                exp_s1_q.push_back(9'(model(8, int'(a), int'(ci))));
                t_s1_q.push_back(cyc);
            end
        end
    end

    // Scoreboard for dut_s8 (never stalled, so latency is always checked).
    always @(negedge clk) begin
        logic [8:0] e;
        int t0;
        if (rst) begin
            exp_s8_q.delete(); t_s8_q.delete();
        end else begin
            if (out_valid_s8) begin
                checks++;
                if (exp_s8_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_s8 extra beat got co=%b z=%h", co_s8, z_s8);
                end else begin
                    e = exp_s8_q.pop_front(); t0 = t_s8_q.pop_front();
                    if ({co_s8, z_s8} !== e || (cyc - t0) != 8) begin
                        failures++;
                        $display("FAIL sb_s8 got co=%b z=%h lat=%0d expected co=%b z=%h lat=8",
                                 co_s8, z_s8, cyc - t0, e[8], e[7:0]);
                    end
                end
            end
            if (in_valid && in_ready_s8) begin
                exp_s8_q.push_back(9'(model(8, int'(a), int'(ci))));
                t_s8_q.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 8'($urandom); ci = 1'b1; out_ready = 1'b1;
        in_valid2 = 1'b1; out_ready2 = 1'b1;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL rst_in_ready got %b expected 0", in_ready);
        end
        checks++;
        if ({out_valid, co, z} !== 10'h000) begin
            failures++; $display("FAIL rst_outputs got v=%b co=%b z=%h expected 0", out_valid, co, z);
        end
        checks++;
        if ({in_ready2, out_valid2, co2, z2} !== 15'h0000) begin
            failures++; $display("FAIL rst_w12 got rdy=%b v=%b co=%b z=%h expected 0", in_ready2, out_valid2, co2, z2);
        end
        rst = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_release_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_wrap();
        in_valid = 1'b1; a = 8'h00; ci = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL wrap_early got out_valid=%b expected 0", out_valid);
        end
        tick();
        checks++;
        if ({out_valid, co, z} !== {1'b1, 1'b1, 8'hFF}) begin
            failures++; $display("FAIL wrap got v=%b co=%b z=%h expected v=1 co=1 z=ff", out_valid, co, z);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta[4] = '{8'h10, 8'h10, 8'h80, 8'hFF};
        logic       tc[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] ez[4] = '{8'h0F, 8'h10, 8'h7F, 8'hFE};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; a = ta[i]; ci = tc[i];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                checks++;
                if ({out_valid, co, z} !== {1'b1, 1'b0, ez[i-1]}) begin
                    failures++;
                    $display("FAIL b2b_%0d got v=%b co=%b z=%h expected v=1 co=0 z=%h", i - 1, out_valid, co, z, ez[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] hz;
        logic       hc;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = 8'($urandom); ci = 1'($urandom);
            tick();
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            failures++; $display("FAIL stall_full got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready);
        end
        hz = z; hc = co;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); ci = 1'($urandom);
            tick();
            checks++;
            if ({out_valid, in_ready, co, z} !== {1'b1, 1'b0, hc, hz}) begin
                failures++;
                $display("FAIL stall_hold_%0d got v=%b rdy=%b co=%b z=%h expected v=1 rdy=0 co=%b z=%h",
                         i, out_valid, in_ready, co, z, hc, hz);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL stall_drain got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 8'($urandom); ci = 1'($urandom);
            tick();
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        checks++;
        if ({out_valid, co, z} !== 10'h000) begin
            failures++; $display("FAIL midrst got v=%b co=%b z=%h expected 0", out_valid, co, z);
        end
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL midrst_ghost_%0d got out_valid=%b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            a          = 8'($urandom);
            ci         = 1'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            in_valid2  = ($urandom_range(0, 3) != 0);
            a2         = 12'($urandom_range(0, 7) == 0 ? 0 : $urandom);
            ci2        = 1'($urandom);
            out_ready2 = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (exp_q.size() + exp2_q.size() + exp_s1_q.size() + exp_s8_q.size() != 0) begin
            failures++;
            $display("FAIL random_drain got %0d/%0d/%0d/%0d pending expected 0",
                     exp_q.size(), exp2_q.size(), exp_s1_q.size(), exp_s8_q.size());
        end
    endtask

    task automatic test_exhaustive();
        logic [8:0] v;
        out_ready = 1'b1;
        lat_chk = 1'b1;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            in_valid = 1'b1; a = v[7:0]; ci = v[8];
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        lat_chk = 1'b0;
        checks++;
        if (exp_q.size() + exp_s1_q.size() + exp_s8_q.size() != 0) begin
            failures++;
            $display("FAIL exh_drain got %0d/%0d/%0d pending expected 0",
                     exp_q.size(), exp_s1_q.size(), exp_s8_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        test_random();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
